// File: rtl/alu_issue_pkg.sv
// Shared constants for the ALU issue/write-back stage: opcodes, FSM states and
// instruction field positions.
package alu_issue_pkg;

  localparam int unsigned DATA_W   = 4;
  localparam int unsigned RF_DEPTH = 4;
  localparam int unsigned ADDR_W   = 2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  // in_instr = {op[8:6], rd[5:4], rs1[3:2], rs2[1:0]}
  localparam int unsigned OP_MSB  = 8;
  localparam int unsigned OP_LSB  = 6;
  localparam int unsigned RD_MSB  = 5;
  localparam int unsigned RD_LSB  = 4;
  localparam int unsigned RS1_MSB = 3;
  localparam int unsigned RS1_LSB = 2;
  localparam int unsigned RS2_MSB = 1;
  localparam int unsigned RS2_LSB = 0;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StExec = 2'b01,
    StWb   = 2'b10
  } state_e;

endpackage

// File: rtl/alu_rf_4x4.sv
// 4x4-bit register file: two combinational read ports, a write-back port and a
// host port; write-back wins when both target the same entry.
module alu_rf_4x4
  import alu_issue_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_a_addr,
  output logic [DATA_W-1:0] rd_a_data,
  input  logic [ADDR_W-1:0] rd_b_addr,
  output logic [DATA_W-1:0] rd_b_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              host_en,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data
);

  logic [DATA_W-1:0] mem_q [RF_DEPTH];

  assign rd_a_data = mem_q[rd_a_addr];
  assign rd_b_data = mem_q[rd_b_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < RF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < RF_DEPTH; i++) begin
        if (wb_en && (wb_addr == ADDR_W'(i))) begin
          mem_q[i] <= wb_data;
        end else if (host_en && (host_addr == ADDR_W'(i))) begin
          mem_q[i] <= host_data;
        end
      end
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/write-back controller for the external 4-bit ALU: IDLE accepts and
// latches operands, EXEC drives the ALU and writes back, WB pulses res_valid.
module alu_issue_ctrl
  import alu_issue_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [8:0]        in_instr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [2:0]        ALU_Sel,
  input  logic [DATA_W-1:0] ALU_Out,
  input  logic              Carry_Out,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic [ADDR_W-1:0] res_rd,
  output logic              carry_flag
);

  state_e            state_q, state_d;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] opa_q, opb_q;
  logic [DATA_W-1:0] rs1_data, rs2_data;
  logic              accept;
  logic              wb_en;
  logic              carry_wb;

  alu_rf_4x4 u_rf (
    .clk       (clk),
    .rst       (rst),
    .rd_a_addr (in_instr[RS1_MSB:RS1_LSB]),
    .rd_a_data (rs1_data),
    .rd_b_addr (in_instr[RS2_MSB:RS2_LSB]),
    .rd_b_data (rs2_data),
    .wb_en     (wb_en),
    .wb_addr   (rd_q),
    .wb_data   (ALU_Out),
    .host_en   (wr_en),
    .host_addr (wr_addr),
    .host_data (wr_data)
  );

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    wb_en     = 1'b0;
    A         = '0;
    B         = '0;
    ALU_Sel   = OP_ADD;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) state_d = StExec;
      end
      StExec: begin
        A       = opa_q;
        B       = opb_q;
        ALU_Sel = op_q;
        wb_en   = 1'b1;
        state_d = StWb;
      end
      StWb: begin
        res_valid = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign accept   = in_valid && in_ready;
  // Only add/sub produce a meaningful carry; logic ops and shifts clear the flag.
  assign carry_wb = ((op_q == OP_ADD) || (op_q == OP_SUB)) ? Carry_Out : 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      op_q       <= '0;
      rd_q       <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      res_data   <= '0;
      res_rd     <= '0;
      carry_flag <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= in_instr[OP_MSB:OP_LSB];
        rd_q  <= in_instr[RD_MSB:RD_LSB];
        opa_q <= rs1_data;
        opb_q <= rs2_data;
      end
      if (wb_en) begin
        res_data   <= ALU_Out;
        res_rd     <= rd_q;
        carry_flag <= carry_wb;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural ALU and register-file model.
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] in_instr;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic [3:0] A, B;
  logic [2:0] ALU_Sel;
  logic [3:0] ALU_Out;
  logic       Carry_Out;
  logic       res_valid;
  logic [3:0] res_data;
  logic [1:0] res_rd;
  logic       carry_flag;

  typedef struct {
    logic [3:0] data;
    logic [1:0] rd;
    logic       carry;
    longint     t;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] rf_m [4];
  int         n_cmp = 0;
  int         n_err = 0;
  longint     last_acc = 0;

  always #5 clk = ~clk;

  function automatic logic [4:0] alu_ref(input logic [2:0] op, input logic [3:0] a,
                                         input logic [3:0] b);
    logic [4:0] r;
    case (op)
      3'b000:  r = {1'b0, a} + {1'b0, b};
      3'b001:  r = {1'b0, a} - {1'b0, b};
      3'b010:  r = {1'b0, a & b};
      3'b011:  r = {1'b0, a | b};
      3'b100:  r = {1'b0, a ^ b};
      3'b101:  r = {1'b0, ~a};
      3'b110:  r = {1'b0, a[2:0], 1'b0};
      default: r = {1'b0, 1'b0, a[3:1]};
    endcase
    return r;
  endfunction

  assign {Carry_Out, ALU_Out} = alu_ref(ALU_Sel, A, B);

  alu_issue_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .A          (A),
    .B          (B),
    .ALU_Sel    (ALU_Sel),
    .ALU_Out    (ALU_Out),
    .Carry_Out  (Carry_Out),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_rd     (res_rd),
    .carry_flag (carry_flag)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Result monitor: every res_valid cycle must match the oldest expected result.
  always @(negedge clk) begin
    if (res_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_res_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("res_data", res_data, e.data);
        check_eq("res_rd", res_rd, e.rd);
        check_eq("carry_flag", carry_flag, e.carry);
        check_eq("res_latency", 32'($time - e.t), 0);
      end
    end
  end

  task automatic host_write(input logic [1:0] addr, input logic [3:0] data);
    wr_en = 1'b1; wr_addr = addr; wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
    rf_m[addr] = data;
  endtask

  // Called on a negedge; returns on the negedge inside EXEC.
  task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, input bit keep, input bit expect_res);
    int         guard;
    logic [4:0] r;
    logic [3:0] opa, opb;
    exp_t       e;
    guard    = 0;
    in_valid = 1'b1;
    in_instr = {op, rd, rs1, rs2};
    while (in_ready !== 1'b1 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    if (in_ready !== 1'b1) begin
      check_eq("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    last_acc = $time;
    opa = rf_m[rs1];
    opb = rf_m[rs2];
    r   = alu_ref(op, opa, opb);
    if (expect_res) begin
      e.data = r[3:0]; e.rd = rd; e.carry = r[4]; e.t = $time + 20;
      sb.push_back(e);
      rf_m[rd] = r[3:0];
    end
    @(negedge clk);
    check_eq("exec_A", A, opa);
    check_eq("exec_B", B, opb);
    check_eq("exec_sel", ALU_Sel, op);
    check_eq("exec_in_ready", in_ready, 0);
    if (!keep) in_valid = 1'b0;
  endtask

  // OR r,r,r returns rf[r] without changing it.
  task automatic probe(input logic [1:0] r);
    issue(3'b011, r, r, r, 1'b0, 1'b1);
  endtask

  initial begin
    longint t1;
    rst = 1'b1; in_valid = 1'b0; in_instr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    for (int i = 0; i < 4; i++) rf_m[i] = '0;
    @(negedge clk); @(negedge clk);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_res_valid", res_valid, 0);
    check_eq("rst_res_data", res_data, 0);
    check_eq("rst_res_rd", res_rd, 0);
    check_eq("rst_carry", carry_flag, 0);
    check_eq("rst_abs", {A, B, ALU_Sel}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Abort mid-EXEC: no write-back, ready immediately
    host_write(2'd1, 4'd5);
    issue(3'b000, 2'd2, 2'd1, 2'd1, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check_eq("abort_in_ready", in_ready, 1);
    check_eq("abort_res_valid", res_valid, 0);
    check_eq("abort_carry", carry_flag, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) rf_m[i] = '0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) probe(2'(i));

    // ADD with carry out
    host_write(2'd0, 4'd9);
    host_write(2'd1, 4'd8);
    issue(3'b000, 2'd2, 2'd0, 2'd1, 1'b0, 1'b1);
    @(negedge clk);
    probe(2'd2);

    // SUB with borrow, then AND clears the flag
    host_write(2'd0, 4'd3);
    host_write(2'd1, 4'd5);
    issue(3'b001, 2'd3, 2'd0, 2'd1, 1'b0, 1'b1);
    issue(3'b010, 2'd3, 2'd0, 2'd0, 1'b0, 1'b1);

    // Back-to-back shifts with in_valid held high
    @(negedge clk);
    host_write(2'd0, 4'b1001);
    issue(3'b110, 2'd0, 2'd0, 2'd0, 1'b1, 1'b1);
    t1 = last_acc;
    issue(3'b111, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1);
    check_eq("accept_spacing", 32'(last_acc - t1), 30);

    // Write-back beats host write to the same register
    issue(3'b000, 2'd1, 2'd0, 2'd1, 1'b0, 1'b1);
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 4'd7;
    @(negedge clk);
    wr_en = 1'b0;
    probe(2'd1);
    // Host write to a different register on the write-back edge lands
    issue(3'b000, 2'd1, 2'd0, 2'd1, 1'b0, 1'b1);
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 4'd7;
    @(negedge clk);
    wr_en = 1'b0;
    rf_m[2] = 4'd7;
    probe(2'd2);
    probe(2'd1);

    // rd == rs1 == rs2 hazard
    host_write(2'd0, 4'd6);
    issue(3'b100, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1);
    issue(3'b000, 2'd1, 2'd0, 2'd0, 1'b0, 1'b1);

    // Random mix over all opcodes
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 1) == 1) host_write(2'($urandom_range(0, 3)), 4'($urandom));
      issue(3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 1'b0, 1'b1);
    end

    repeat (5) @(negedge clk);
    check_eq("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
